// File: rtl/hazard_mode_ctrl.sv
// Debounced mode selector for the hazard-light sequencer: synchronizes and debounces sw, then commits mode on step ticks.
// Optional one-cycle mode_chg pulse is built when HAZARD_MODE_CHG_PULSE_EN is defined.
module hazard_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sw,
    output logic [1:0] mode,
    output logic       tick
`ifdef HAZARD_MODE_CHG_PULSE_EN
    ,
    output logic       mode_chg
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int DW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_STABLE,
        ST_SETTLE,
        ST_PENDING
    } state_t;

    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    sw_map;
    logic [DW-1:0] divcnt_q, divcnt_d;
    logic          tick_q, tick_d;
    state_t        state_q, state_d;
    logic [1:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pend_q, pend_d;
    logic [1:0]    mode_q, mode_d;

    // The illegal switch code behaves exactly like hazard, so it can never reach mode.
    assign sw_map = (sync2_q == 2'b11) ? 2'b00 : sync2_q;

    always_comb begin
        divcnt_d = (divcnt_q == DW'(TICK_DIV - 1)) ? '0 : divcnt_q + 1'b1;
        tick_d   = (divcnt_d == DW'(TICK_DIV - 1));
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        mode_d  = mode_q;
        if (sw_map != cand_q) begin
            cand_d  = sw_map;
            cnt_d   = '0;
            pend_d  = 2'b00;
            state_d = ST_SETTLE;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        if (cand_q != mode_q) begin
                            pend_d  = cand_q;
                            state_d = ST_PENDING;
                        end else begin
                            state_d = ST_STABLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PENDING: begin
                    // Commit only on a step boundary so the sequencer never changes mode mid-step.
                    if (tick_q) begin
                        mode_d  = pend_q;
                        state_d = ST_STABLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 2'b00;
            sync2_q  <= 2'b00;
            divcnt_q <= '0;
            tick_q   <= 1'b0;
            state_q  <= ST_STABLE;
            cand_q   <= 2'b00;
            cnt_q    <= '0;
            pend_q   <= 2'b00;
            mode_q   <= 2'b00;
        end else begin
            sync1_q  <= sw;
            sync2_q  <= sync1_q;
            divcnt_q <= divcnt_d;
            tick_q   <= tick_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            mode_q   <= mode_d;
        end
    end

    assign mode = mode_q;
    assign tick = tick_q;

`ifdef HAZARD_MODE_CHG_PULSE_EN
    logic mode_chg_q, mode_chg_d;

    assign mode_chg_d = (mode_d != mode_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_chg_q <= 1'b0;
        end else begin
            mode_chg_q <= mode_chg_d;
        end
    end

    assign mode_chg = mode_chg_q;
`endif

endmodule
